// File: rtl/compute_req_pkg.sv
// compute_req_pkg: FSM encoding and shared widths for the compute request initiator.
package compute_req_pkg;
    typedef enum logic [1:0] {
        IDLE       = 2'd0,
        REQ        = 2'd1,
        WAIT_VALID = 2'd2,
        HOLDOFF    = 2'd3
    } state_e;
    localparam int DEF_DATA_W = 32;
    localparam int CNT_W      = 16;
endpackage

// File: rtl/req_result_fifo.sv
// req_result_fifo: synchronous result FIFO with async active-low reset; head reads zero while empty.
module req_result_fifo #(
    parameter int DATA_W     = 32,
    parameter int FIFO_DEPTH = 4
) (
    input  logic              clk_i,
    input  logic              rstn_i,
    input  logic              push_i,
    input  logic [DATA_W-1:0] wdata_i,
    input  logic              pop_i,
    output logic [DATA_W-1:0] rdata_o,
    output logic              empty_o,
    output logic              full_o
);
    localparam int AW = $clog2(FIFO_DEPTH);
    logic [DATA_W-1:0] mem_q [FIFO_DEPTH];
    logic [AW-1:0]     wr_ptr_q, rd_ptr_q;
    logic [AW:0]       cnt_q;
    logic              do_push, do_pop;
    assign empty_o = cnt_q == '0;
    assign full_o  = cnt_q == (AW+1)'(FIFO_DEPTH);
    assign do_push = push_i & ~full_o;
    assign do_pop  = pop_i & ~empty_o;
    assign rdata_o = empty_o ? '0 : mem_q[rd_ptr_q];
    always_ff @(posedge clk_i) begin
        if (do_push) mem_q[wr_ptr_q] <= wdata_i;
    end
    always_ff @(posedge clk_i or negedge rstn_i) begin
        if (!rstn_i) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            cnt_q    <= '0;
        end else begin
            wr_ptr_q <= wr_ptr_q + AW'(do_push);
            rd_ptr_q <= rd_ptr_q + AW'(do_pop);
            cnt_q    <= cnt_q + (AW+1)'(do_push) - (AW+1)'(do_pop);
        end
    end
endmodule

// File: rtl/compute_req_initiator.sv
// compute_req_initiator: one compute_req per accepted operand, results queued in a FIFO, spacing and timeout.
// Optional COMPUTE_REQ_STATS_EN adds saturating request/timeout counters.
module compute_req_initiator
    import compute_req_pkg::*;
#(
    parameter int DATA_W     = DEF_DATA_W,
    parameter int PERIOD     = 50,
    parameter int TIMEOUT    = 255,
    parameter int FIFO_DEPTH = 4
) (
    input  logic              clk_i,
    input  logic              rstn_i,
    input  logic              enable_i,
    input  logic [DATA_W-1:0] operand_i,
    input  logic              operand_valid_i,
    output logic              operand_ready_o,
    output logic              compute_req_o,
    output logic [DATA_W-1:0] data_o,
    input  logic              valid_i,
    input  logic [DATA_W-1:0] data_i,
    output logic [DATA_W-1:0] result_o,
    output logic              result_valid_o,
    input  logic              result_ready_i,
    output logic              timeout_o,
    output logic              spurious_o,
`ifdef COMPUTE_REQ_STATS_EN
    output logic              busy_o,
    output logic [CNT_W-1:0]  req_count_o,
    output logic [CNT_W-1:0]  timeout_count_o
`else
    output logic              busy_o
`endif
);
    state_e            state_q;
    logic [CNT_W-1:0]  cnt_q;
    logic [DATA_W-1:0] data_q;
    logic              req_q, spurious_q, fifo_full, fifo_empty, in_wait, expire;
    assign in_wait = state_q == WAIT_VALID;
    // Decoded rather than registered so a valid_i on the last wait cycle suppresses the abort.
    assign expire          = in_wait & ~valid_i & (cnt_q == CNT_W'(TIMEOUT - 1));
    assign operand_ready_o = (state_q == IDLE) & enable_i & ~fifo_full;
    assign compute_req_o   = req_q;
    assign data_o          = data_q;
    assign timeout_o       = expire;
    assign spurious_o      = spurious_q;
    assign busy_o          = state_q != IDLE;
    assign result_valid_o  = ~fifo_empty;
    req_result_fifo #(
        .DATA_W    (DATA_W),
        .FIFO_DEPTH(FIFO_DEPTH)
    ) u_fifo (
        .clk_i  (clk_i),
        .rstn_i (rstn_i),
        .push_i (in_wait & valid_i),
        .wdata_i(data_i),
        .pop_i  (result_ready_i),
        .rdata_o(result_o),
        .empty_o(fifo_empty),
        .full_o (fifo_full)
    );
    always_ff @(posedge clk_i or negedge rstn_i) begin
        if (!rstn_i) begin
            state_q    <= IDLE;
            cnt_q      <= '0;
            data_q     <= '0;
            req_q      <= 1'b0;
            spurious_q <= 1'b0;
        end else begin
            req_q <= 1'b0;
            if (valid_i && !in_wait) spurious_q <= 1'b1;
            case (state_q)
                IDLE: begin
                    if (operand_valid_i && operand_ready_o) begin
                        data_q  <= operand_i;
                        req_q   <= 1'b1;
                        state_q <= REQ;
                    end
                end
                REQ: begin
                    cnt_q   <= '0;
                    state_q <= WAIT_VALID;
                end
                WAIT_VALID: begin
                    if (valid_i || expire) begin
                        cnt_q   <= '0;
                        state_q <= HOLDOFF;
                    end else cnt_q <= cnt_q + CNT_W'(1);
                end
                HOLDOFF: begin
                    if (cnt_q == CNT_W'(PERIOD - 1)) begin
                        cnt_q   <= '0;
                        state_q <= IDLE;
                    end else cnt_q <= cnt_q + CNT_W'(1);
                end
            endcase
        end
    end
`ifdef COMPUTE_REQ_STATS_EN
    logic [CNT_W-1:0] req_cnt_q, to_cnt_q;
    assign req_count_o     = req_cnt_q;
    assign timeout_count_o = to_cnt_q;
    always_ff @(posedge clk_i or negedge rstn_i) begin
        if (!rstn_i) begin
            req_cnt_q <= '0;
            to_cnt_q  <= '0;
        end else begin
            if (state_q == REQ && req_cnt_q != '1) req_cnt_q <= req_cnt_q + CNT_W'(1);
            if (expire && to_cnt_q != '1) to_cnt_q <= to_cnt_q + CNT_W'(1);
        end
    end
`endif
endmodule

// File: tb/tb_compute_req_initiator.sv
// tb_compute_req_initiator: directed stimulus with a result scoreboard checked by an independent monitor.
module tb_compute_req_initiator;
    import compute_req_pkg::*;
    localparam int DW = 32;
    logic clk = 1'b0, rstn = 1'b0, enable = 1'b0, operand_valid = 1'b0, valid = 1'b0, result_ready = 1'b0;
    logic [DW-1:0] operand = '0, data_in = '0;
    logic operand_ready, compute_req, result_valid, timeout, spurious, busy;
    logic [DW-1:0] data_out, result;
`ifdef COMPUTE_REQ_STATS_EN
    logic [CNT_W-1:0] req_count, timeout_count;
`endif
    int n_vec = 0, n_err = 0, cyc = 0;
    logic [DW-1:0] sb_q[$];

    compute_req_initiator #(.DATA_W(DW), .PERIOD(50), .TIMEOUT(8), .FIFO_DEPTH(4)) dut (
        .clk_i(clk), .rstn_i(rstn), .enable_i(enable),
        .operand_i(operand), .operand_valid_i(operand_valid), .operand_ready_o(operand_ready),
        .compute_req_o(compute_req), .data_o(data_out), .valid_i(valid), .data_i(data_in),
        .result_o(result), .result_valid_o(result_valid), .result_ready_i(result_ready),
        .timeout_o(timeout), .spurious_o(spurious),
`ifdef COMPUTE_REQ_STATS_EN
        .busy_o(busy), .req_count_o(req_count), .timeout_count_o(timeout_count)
`else
        .busy_o(busy)
`endif
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string name, input logic [DW-1:0] act, input logic [DW-1:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %h expected %h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    task automatic chk1(input string name, input logic act, input logic exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %b expected %b (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    // Monitor: every pop handshake must match the oldest expected result.
    always begin
        @(negedge clk);
        #2;
        if (result_valid === 1'b1 && result_ready === 1'b1) begin
            if (sb_q.size() == 0) begin
                n_vec++;
                n_err++;
                $display("FAIL sb_extra: got result %h expected no result (cycle %0d)", result, cyc);
            end else chk("sb_result", result, sb_q.pop_front());
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog: got no finish expected finish before time limit");
        $fatal(1);
    end

    task automatic tick(input int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic send(input logic [DW-1:0] op, output int r);
        int i = 0;
        operand = op;
        operand_valid = 1'b1;
        while (!operand_ready && i < 200) begin
            @(negedge clk);
            i++;
        end
        chk1("accept_ready", operand_ready, 1'b1);
        @(negedge clk);
        operand_valid = 1'b0;
        r = cyc;
        chk1("req_pulse", compute_req, 1'b1);
        chk("data_o_req", data_out, op);
    endtask

    task automatic respond(input int dly, input logic [DW-1:0] d, output int v);
        tick(dly);
        valid = 1'b1;
        data_in = d;
        sb_q.push_back(d);
        v = cyc;
        tick(1);
        valid = 1'b0;
    endtask

    task automatic wait_idle();
        int i = 0;
        while (busy && i < 200) begin
            tick(1);
            i++;
        end
        chk1("idle", busy, 1'b0);
    endtask

    initial begin
        int r, r2, v;
        tick(2);
        chk1("rst_busy", busy, 1'b0);
        chk1("rst_req", compute_req, 1'b0);
        chk("rst_data_o", data_out, 32'h0);
        chk1("rst_rvalid", result_valid, 1'b0);
        chk1("rst_ready", operand_ready, 1'b0);
        chk1("rst_spurious", spurious, 1'b0);
        chk1("rst_timeout", timeout, 1'b0);
        rstn = 1'b1;
        enable = 1'b1;
        result_ready = 1'b1;
        tick(1);
        chk1("idle_ready", operand_ready, 1'b1);
        // 1 basic
        send(32'h5, r);
        tick(1);
        chk1("req_one_cycle", compute_req, 1'b0);
        chk1("busy_wait", busy, 1'b1);
        respond(2, 32'hA5, v);
        chk("data_o_hold", data_out, 32'h5);
        chk1("rvalid_next", result_valid, 1'b1);
        wait_idle();
        // 2 spacing
        send(32'h1, r);
        tick(1);
        respond(1, 32'h11, v);
        chk1("holdoff_ready", operand_ready, 1'b0);
        send(32'h2, r2);
        chk("spacing", 32'(r2 - v), 32'd52);
        tick(1);
        respond(1, 32'h22, v);
        wait_idle();
        // 3 timeout
        send(32'h3, r);
        for (int i = 0; i < 20 && !timeout; i++) tick(1);
        chk("timeout_at", 32'(cyc - r), 32'd8);
        chk1("timeout_fifo", result_valid, 1'b0);
        tick(1);
        chk1("timeout_pulse", timeout, 1'b0);
        chk1("timeout_holdoff", busy, 1'b1);
`ifdef COMPUTE_REQ_STATS_EN
        chk("stat_timeouts", {16'h0, timeout_count}, 32'd1);
        chk("stat_reqs", {16'h0, req_count}, 32'd4);
`endif
        wait_idle();
        // 4 FIFO full
        result_ready = 1'b0;
        for (int k = 0; k < 4; k++) begin
            send(32'h10 + k, r);
            tick(1);
            respond(1, 32'hB0 + k, v);
            wait_idle();
        end
        chk1("full_ready", operand_ready, 1'b0);
        chk1("full_rvalid", result_valid, 1'b1);
        operand = 32'h14;
        operand_valid = 1'b1;
        tick(3);
        chk1("full_hold", busy, 1'b0);
        result_ready = 1'b1;
        tick(1);
        result_ready = 1'b0;
        chk1("pop_ready", operand_ready, 1'b1);
        send(32'h14, r);
        tick(1);
        respond(1, 32'hB4, v);
        wait_idle();
        result_ready = 1'b1;
        for (int i = 0; i < 10 && result_valid; i++) tick(1);
        chk1("drained", result_valid, 1'b0);
        // 5 spurious and valid on the expiry cycle
        chk1("spur_before", spurious, 1'b0);
        valid = 1'b1;
        data_in = 32'hDEAD;
        tick(1);
        valid = 1'b0;
        chk1("spur_set", spurious, 1'b1);
        chk1("spur_fifo", result_valid, 1'b0);
        send(32'h6, r);
        tick(7);
        chk1("pre_expiry", timeout, 1'b0);
        tick(1);
        valid = 1'b1;
        data_in = 32'hC0FFEE;
        sb_q.push_back(32'hC0FFEE);
        #1;
        chk1("valid_wins", timeout, 1'b0);
        tick(1);
        valid = 1'b0;
        chk1("post_expiry", timeout, 1'b0);
        chk1("late_rvalid", result_valid, 1'b1);
`ifdef COMPUTE_REQ_STATS_EN
        chk("stat_timeouts2", {16'h0, timeout_count}, 32'd1);
        chk("stat_reqs2", {16'h0, req_count}, 32'd10);
`endif
        wait_idle();
        // 6 reset mid-WAIT_VALID with two results queued
        result_ready = 1'b0;
        send(32'h20, r);
        tick(1);
        respond(1, 32'hD1, v);
        wait_idle();
        send(32'h21, r);
        tick(1);
        respond(1, 32'hD2, v);
        wait_idle();
        send(32'h22, r);
        tick(2);
        rstn = 1'b0;
        sb_q.delete();
        #1;
        chk1("mid_rst_busy", busy, 1'b0);
        chk1("mid_rst_req", compute_req, 1'b0);
        chk("mid_rst_data_o", data_out, 32'h0);
        chk1("mid_rst_rvalid", result_valid, 1'b0);
        chk("mid_rst_result", result, 32'h0);
        chk1("mid_rst_spurious", spurious, 1'b0);
        chk1("mid_rst_timeout", timeout, 1'b0);
`ifdef COMPUTE_REQ_STATS_EN
        chk("mid_rst_reqs", {16'h0, req_count}, 32'd0);
`endif
        tick(1);
        rstn = 1'b1;
        tick(1);
        result_ready = 1'b1;
        send(32'h23, r);
        tick(1);
        respond(1, 32'hE7, v);
        wait_idle();
        tick(2);
        chk("sb_left", 32'(sb_q.size()), 32'd0);
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end
endmodule
